// File: rtl/parity_frame_serializer_if.sv
// parity_frame_serializer_if: word handshake in, framed serial bit stream out.
interface parity_frame_serializer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              i_stall;
  logic              o_x;
  logic              o_bit_valid;
  logic              o_sof;
  logic              o_eof;
  logic [7:0]        o_frame_cnt;
  modport master (output i_data, i_valid, i_stall,
                  input  o_ready, o_x, o_bit_valid, o_sof, o_eof, o_frame_cnt);
  modport slave  (input  i_data, i_valid, i_stall,
                  output o_ready, o_x, o_bit_valid, o_sof, o_eof, o_frame_cnt);
endinterface

// File: rtl/parity_frame_serializer.sv
// parity_frame_serializer: shifts a word out bit-serially followed by one parity bit.
module parity_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1,
  parameter bit ODD_PARITY = 0
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  parity_frame_serializer_if.slave bus
);
  localparam int IW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] sr, sr_n, din;
  logic [7:0]        cnt, cnt_n;
  logic              par, par_n, x, x_n, bv, bv_n, sof, sof_n, eof, eof_n;
  logic              rst_sync, ready, accept, last;
  // Store the word pre-ordered so bit idx is always the idx-th bit shifted out
  for (genvar i = 0; i < DATA_W; i++) begin : g_ord
    assign din[i] = bus.i_data[LSB_FIRST ? i : DATA_W-1-i];
  end
  assign ready  = rst_sync & ~bus.i_stall & (state != SHIFT);
  assign accept = bus.i_valid & ready;
  assign last   = idx == IW'(DATA_W-1);
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sr_n    = sr;
    par_n   = par;
    cnt_n   = cnt;
    x_n     = x;
    bv_n    = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    if (!bus.i_stall) begin
      cnt_n = (state == PARITY) ? cnt + 8'd1 : cnt;
      if (accept) begin
        state_n = SHIFT;
        idx_n   = '0;
        sr_n    = din;
        par_n   = (^bus.i_data) ^ ODD_PARITY;
        x_n     = din[0];
        bv_n    = 1'b1;
        sof_n   = 1'b1;
      end else if (state == SHIFT) begin
        bv_n    = 1'b1;
        state_n = last ? PARITY : SHIFT;
        idx_n   = last ? idx : idx + 1'b1;
        x_n     = last ? par : sr[idx + 1'b1];
        eof_n   = last;
      end else begin
        state_n = IDLE;
        x_n     = 1'b0;
      end
    end
  end
  // One-flop release stage: the first accept lands on the second edge after release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 1'b0;
    else          rst_sync <= 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx   <= '0;
      sr    <= '0;
      par   <= 1'b0;
      cnt   <= '0;
      x     <= 1'b0;
      bv    <= 1'b0;
      sof   <= 1'b0;
      eof   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      sr    <= sr_n;
      par   <= par_n;
      cnt   <= cnt_n;
      x     <= x_n;
      bv    <= bv_n;
      sof   <= sof_n;
      eof   <= eof_n;
    end
  end
  assign bus.o_ready     = ready;
  assign bus.o_x         = x;
  assign bus.o_bit_valid = bv;
  assign bus.o_sof       = sof;
  assign bus.o_eof       = eof;
  assign bus.o_frame_cnt = cnt;
endmodule
